// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the R-type control decoder.
//
// Holds the PC and a word-addressed instruction memory that is written
// through a load port. After a start pulse it fetches one registered
// instruction per cycle, from PC 0 through the programmed length, then
// stops and raises done.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   i_imem_we       load-port write enable
//   i_imem_waddr    load-port word address
//   i_imem_wdata    load-port write data
//   i_prog_len      instructions to execute (clamped to IMEM_DEPTH)
//   i_start         begin or restart execution at PC 0
//   i_stall         hold outputs and PC
//   o_instr         registered instruction word
//   o_opcode .. o_funct  MIPS field slices of o_instr
//   o_pc_out        byte address of o_instr
//   o_valid         o_instr/o_pc_out meaningful this cycle
//   o_done          program finished (level)
module instr_fetch #(
  parameter int unsigned IMEM_DEPTH = 64,
  localparam int unsigned AW = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_imem_we,
  input  logic [AW-1:0] i_imem_waddr,
  input  logic [31:0]   i_imem_wdata,
  input  logic [AW:0]   i_prog_len,
  input  logic          i_start,
  input  logic          i_stall,
  output logic [31:0]   o_instr,
  output logic [5:0]    o_opcode,
  output logic [4:0]    o_rs,
  output logic [4:0]    o_rt,
  output logic [4:0]    o_rd,
  output logic [4:0]    o_shamt,
  output logic [5:0]    o_funct,
  output logic [31:0]   o_pc_out,
  output logic          o_valid,
  output logic          o_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(IMEM_DEPTH);

  logic [31:0] r_mem [IMEM_DEPTH];
  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_out;
  logic        r_valid;
  logic        r_done;

  logic [AW-1:0] w_idx;
  logic [AW:0]   w_idx_full;
  logic [AW:0]   w_limit;
  logic          w_in_range;

  // One extra index bit so a PC that has run off the end of a full-depth
  // program compares correctly against the limit instead of wrapping.
  assign w_idx      = r_pc[AW+1:2];
  assign w_idx_full = r_pc[AW+2:2];
  assign w_limit    = (i_prog_len > LEN_MAX) ? LEN_MAX : i_prog_len;
  assign w_in_range = (w_idx_full < w_limit);

  // Load port; no reset on storage. Fetch samples r_mem with a non-blocking
  // read on the same edge, so a colliding write yields the old word.
  always_ff @(posedge clk) begin
    if (i_imem_we) begin
      r_mem[i_imem_waddr] <= i_imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= 32'd0;
      r_instr  <= 32'd0;
      r_pc_out <= 32'd0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_pc    <= 32'd0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Restart beats stall, and stall beats the length check.
          if (i_start) begin
            r_pc    <= 32'd0;
            r_valid <= 1'b0;
          end else if (!i_stall) begin
            if (w_in_range) begin
              r_instr  <= r_mem[w_idx];
              r_pc_out <= r_pc;
              r_valid  <= 1'b1;
              r_pc     <= r_pc + 32'd4;
            end else begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_pc    <= 32'd0;
            r_done  <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_instr  = r_instr;
  assign o_opcode = r_instr[31:26];
  assign o_rs     = r_instr[25:21];
  assign o_rt     = r_instr[20:16];
  assign o_rd     = r_instr[15:11];
  assign o_shamt  = r_instr[10:6];
  assign o_funct  = r_instr[5:0];
  assign o_pc_out = r_pc_out;
  assign o_valid  = r_valid;
  assign o_done   = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, plain run, stall, zero length,
// restart from done, async reset mid-run, read-before-write, clamping.
module tb_instr_fetch;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  logic          clk;
  logic          rst;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   prog_len;
  logic          start;
  logic          stall;
  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic [31:0]   pc_out;
  logic          valid;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_imem_we   (imem_we),
    .i_imem_waddr(imem_waddr),
    .i_imem_wdata(imem_wdata),
    .i_prog_len  (prog_len),
    .i_start     (start),
    .i_stall     (stall),
    .o_instr     (instr),
    .o_opcode    (opcode),
    .o_rs        (rs),
    .o_rt        (rt),
    .o_rd        (rd),
    .o_shamt     (shamt),
    .o_funct     (funct),
    .o_pc_out    (pc_out),
    .o_valid     (valid),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_fields"}, {opcode, rs, rt, rd, shamt, funct}, 32'd0);
  endtask

  // Expect a valid R-type word 0x002218xx with rs=1 rt=2 rd=3.
  task automatic chk_fetch(input string tag, input logic [31:0] exp_pc,
                           input logic [5:0] exp_funct);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
    chk({tag, "_pc"}, pc_out, exp_pc);
    chk({tag, "_funct"}, {26'd0, funct}, {26'd0, exp_funct});
    chk({tag, "_regs"}, {17'd0, rs, rt, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk({tag, "_op"}, {26'd0, opcode}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] prog [3];
  int          nvalid;
  logic [31:0] last_pc;

  initial begin
    prog[0] = 32'h0022_1820;
    prog[1] = 32'h0022_1822;
    prog[2] = 32'h0022_1824;
    rst = 1'b1;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;
    prog_len = '0;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");
    repeat (5) tick();
    chk_zero("idle_hold");

    // Load program
    for (int i = 0; i < 3; i++) begin
      imem_we = 1'b1;
      imem_waddr = AW'(i);
      imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;

    // Plain run
    prog_len = 7'd3;
    pulse_start();
    chk("run_lat_valid", {31'd0, valid}, 32'd0);
    tick();
    chk_fetch("run0", 32'd0, 6'd32);
    chk("run0_instr", instr, 32'h0022_1820);
    tick();
    chk_fetch("run1", 32'd4, 6'd34);
    tick();
    chk_fetch("run2", 32'd8, 6'd36);
    tick();
    chk("run_end_valid", {31'd0, valid}, 32'd0);
    chk("run_end_done", {31'd0, done}, 32'd1);
    tick();
    chk("run_done_hold", {31'd0, done}, 32'd1);

    // Stall while pc_out=4
    pulse_start();
    chk("st_restart_done", {31'd0, done}, 32'd0);
    tick();
    chk_fetch("st0", 32'd0, 6'd32);
    tick();
    chk_fetch("st1", 32'd4, 6'd34);
    stall = 1'b1;
    tick();
    chk("st_hold1_instr", instr, 32'h0022_1822);
    chk("st_hold1_pc", pc_out, 32'd4);
    chk("st_hold1_valid", {31'd0, valid}, 32'd1);
    tick();
    chk("st_hold2_instr", instr, 32'h0022_1822);
    chk("st_hold2_pc", pc_out, 32'd4);
    stall = 1'b0;
    tick();
    chk_fetch("st2", 32'd8, 6'd36);
    tick();
    chk("st_end_done", {31'd0, done}, 32'd1);
    chk("st_end_valid", {31'd0, valid}, 32'd0);

    // Zero length from DONE
    prog_len = 7'd0;
    pulse_start();
    chk("z_done_drop", {31'd0, done}, 32'd0);
    chk("z_valid0", {31'd0, valid}, 32'd0);
    tick();
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_valid1", {31'd0, valid}, 32'd0);

    // Replay from DONE, then async reset while pc_out=4
    prog_len = 7'd3;
    pulse_start();
    chk("rp_done_drop", {31'd0, done}, 32'd0);
    tick();
    chk_fetch("rp0", 32'd0, 6'd32);
    tick();
    chk_fetch("rp1", 32'd4, 6'd34);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk_zero("post_rst_idle");

    // Read-before-write on index 1
    pulse_start();
    tick();
    chk_fetch("rbw0", 32'd0, 6'd32);
    imem_we = 1'b1;
    imem_waddr = AW'(1);
    imem_wdata = 32'hDEAD_BEEF;
    tick();
    imem_we = 1'b0;
    chk("rbw_old", instr, 32'h0022_1822);
    tick();
    tick();
    chk("rbw_done", {31'd0, done}, 32'd1);
    pulse_start();
    tick();
    tick();
    chk("rbw_new", instr, 32'hDEAD_BEEF);
    chk("rbw_new_pc", pc_out, 32'd4);

    // Clamp: prog_len above depth runs exactly IMEM_DEPTH instructions
    prog_len = 7'd100;
    pulse_start();
    nvalid = 0;
    last_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (valid) begin
        nvalid++;
        last_pc = pc_out;
      end
      if (done) break;
    end
    chk("clamp_count", nvalid, IMEM_DEPTH);
    chk("clamp_last_pc", last_pc, 32'd252);
    chk("clamp_done", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the R-type control decoder. Holds the PC and a word-addressed instruction memory (written through a load port). Each cycle it presents one registered instruction, split into MIPS fields, with a valid flag. The decoder consumes opcode/funct; the register file consumes rs/rt/rd. Runs from PC 0 through a programmed length, then stops and reports done.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of 2)
AW, $clog2(IMEM_DEPTH), word-address width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
imem_we  in  1  load-port write enable
imem_waddr  in  AW  load-port word address
imem_wdata  in  32  load-port write data
prog_len  in  AW+1  number of instructions to execute; clamped to IMEM_DEPTH
start  in  1  single-cycle pulse; begins or restarts execution at PC 0
stall  in  1  hold the current outputs and PC
instr  out  32  registered instruction word
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
pc_out  out  32  byte address of instr
valid  out  1  instr/pc_out meaningful this cycle
done  out  1  program finished; level signal

Behaviour:
- One clock domain: clk, with rst asynchronous and active-high. Reset forces pc=0, state IDLE, instr=0, pc_out=0, valid=0, done=0. The memory contents are not reset.
- Field outputs are purely combinational slices of the registered instr.
- Word index = pc[AW+1:2]. pc always advances by 4, and pc[1:0] is always 0.
- State IDLE:
  - start=1 sets pc=0 and moves to FETCH.
  - All other inputs are ignored except the load port.
- State FETCH, stall=0:
  - If index < min(prog_len, IMEM_DEPTH): instr<=imem[index], pc_out<=pc, valid<=1, pc<=pc+4.
  - Otherwise: valid<=0, done<=1, move to DONE.
- State FETCH, stall=1: instr, pc_out, valid and pc all hold. The stall check is made before the length check.
- Latency: a start sampled at edge N gives the first valid instruction after edge N+1. With no stalls, valid then stays high for exactly prog_len consecutive cycles.
- State DONE:
  - done stays high and valid stays low.
  - start=1 sets pc=0, done<=0 and moves to FETCH.
- start in FETCH takes priority over stall and fetch: pc<=0, valid<=0 that cycle, stay in FETCH.
- prog_len=0: start leads to FETCH, then DONE one edge later. valid never asserts.
- Load port:
  - Writes are accepted in any state.
  - A same-cycle write and fetch to the same index returns the OLD word (read-before-write).
  - Writes during FETCH are allowed. Stable program contents during a run are the user's responsibility.
- rst asserted mid-run aborts immediately to the reset values. Execution does not resume until the next start.
- Clamping: any prog_len above IMEM_DEPTH behaves as IMEM_DEPTH. The PC never wraps during a run.

Test Plan:
- Reset → instr=0, pc_out=0, valid=0, done=0, all fields 0. Hold 5 cycles with no start → outputs unchanged.
- Load 0x00221820, 0x00221822, 0x00221824 at indices 0–2; prog_len=3; start → three valid cycles with:
  - funct = 32, 34, 36 in order,
  - rs=1, rt=2, rd=3 on each,
  - pc_out = 0, 4, 8.
  Next edge: valid=0, done=1.
- Same program with stall high for 2 cycles while pc_out=4 → instr 0x00221822 held 3 cycles. Sequence then resumes with pc_out=8. Total of 3 distinct valid instructions.
- prog_len=0, start → done=1 two edges after start, valid never 1. Then start again from DONE → done drops, and with prog_len=3 the full sequence replays from pc_out=0.
- Assert rst while pc_out=4 → all outputs zero asynchronously before the next edge. After release, remain IDLE until start.
- Write 0xDEADBEEF to index 1 in the same cycle the fetch reads index 1 → instr=0x00221822. Restart → index 1 returns 0xDEADBEEF.
